// File: rtl/apb_xfer_ctrl.sv
// apb_xfer_ctrl: AHB-lite slave to APB master transfer sequencer.
// Each accepted AHB address phase becomes one APB SETUP/ACCESS sequence on
// one of four peripherals, which are decoded from haddr[13:12]. Address, size,
// slave and timeout faults return the two-cycle AHB ERROR response.
// Optional build macro: APB_XFER_TIMEOUT_EN adds the ACCESS-phase timeout
// counter and its abort path. Without it, ACCESS waits for pready forever.
module apb_xfer_ctrl #(
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                    pll_core_cpuclk,
  input  logic                    pad_cpu_rst_b,
  input  logic                    hsel,
  input  logic [39:0]             haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [31:0]             hwdata,
  output logic [31:0]             hrdata,
  output logic                    hready,
  output logic [1:0]              hresp,
  output logic [31:0]             paddr,
  output logic [NUM_SLV-1:0]      psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [31:0]             pwdata,
  input  logic [32*NUM_SLV-1:0]   prdata,
  input  logic [NUM_SLV-1:0]      pready,
  input  logic [NUM_SLV-1:0]      pslverr
);

  // The decode is fixed on two address bits, and the timeout counter is 8 bits.
  if (NUM_SLV != 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_param_chk
    $error("apb_xfer_ctrl: NUM_SLV must be 4 and TIMEOUT_CYC in 1..256");
  end

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;

`ifdef APB_XFER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  logic addr_err;
  logic ahb_req;
  logic can_accept;
  logic sel_ready;
  logic sel_err;

  // Decode the incoming AHB address phase and the responses of the selected slave.
  always_comb begin
    ahb_req   = hsel && (htrans == 2'b10 || htrans == 2'b11);
    addr_err  = (haddr[39:16] != '0) || (hsize > 3'b010);
    sel_ready = pready[idx_q];
    sel_err   = pslverr[idx_q];
  end

  // Next-state logic and the AHB/APB outputs that depend on the current state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
`ifdef APB_XFER_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    hready     = 1'b1;
    hresp      = RESP_OKAY;
    hrdata     = '0;
    psel       = '0;
    penable    = 1'b0;
    pwdata     = wdata_q;
    can_accept = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        can_accept = 1'b1;
      end

      ST_SETUP: begin
        // hwdata belongs to this data-phase cycle. It is passed straight through
        // and also registered, so that it holds for the ACCESS cycles.
        hready     = 1'b0;
        psel[idx_q] = 1'b1;
        pwdata     = hwdata;
        wdata_d    = hwdata;
        state_d    = ST_ACCESS;
`ifdef APB_XFER_TIMEOUT_EN
        cnt_d      = '0;
`endif
      end

      ST_ACCESS: begin
        hready      = 1'b0;
        psel[idx_q] = 1'b1;
        penable     = 1'b1;
`ifdef APB_XFER_TIMEOUT_EN
        cnt_d       = cnt_q + 8'd1;
`endif
        if (sel_ready) begin
          if (!write_q) begin
            hrdata = prdata[{idx_q, 5'b00000} +: 32];
          end
          if (sel_err) begin
            state_d = ST_ERR1;
          end else begin
            hready     = 1'b1;
            can_accept = 1'b1;
          end
        end
`ifdef APB_XFER_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = ST_ERR1;
        end
`endif
      end

      ST_ERR1: begin
        hready  = 1'b0;
        hresp   = RESP_ERROR;
        state_d = ST_ERR2;
      end

      ST_ERR2: begin
        hresp      = RESP_ERROR;
        can_accept = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // IDLE, the ACCESS completion cycle and ERR2 all share one accept path.
    // A transfer presented in that cycle goes directly to SETUP, with no IDLE gap.
    if (can_accept) begin
      state_d = ST_IDLE;
      if (ahb_req) begin
        addr_d  = haddr[31:0];
        write_d = hwrite;
        idx_d   = haddr[13:12];
        if (addr_err) begin
          state_d = ST_ERR1;
        end else begin
          state_d = ST_SETUP;
`ifdef APB_XFER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
    end
  end

  assign paddr  = addr_q;
  assign pwrite = write_q;

  // State and transfer-context registers. Reset is asynchronous and returns every output to idle.
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
`ifdef APB_XFER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
`ifdef APB_XFER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// Scoreboard testbench for apb_xfer_ctrl.
// The driver process acts as the AHB master. For each transfer it computes the
// expected response: ERROR or OKAY, the read data and the data-phase length.
// The responder process acts as the APB peripherals, and the monitor processes
// compare the DUT outputs against the queued expectations.
module tb_apb_xfer_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hsel = 1'b0;
  logic [39:0]  haddr = '0;
  logic [1:0]   htrans = '0;
  logic         hwrite = 1'b0;
  logic [2:0]   hsize = '0;
  logic [31:0]  hwdata = '0;
  logic [31:0]  hrdata;
  logic         hready;
  logic [1:0]   hresp;
  logic [31:0]  paddr;
  logic [3:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [127:0] prdata = '0;
  logic [3:0]   pready = '0;
  logic [3:0]   pslverr = '0;

  apb_xfer_ctrl #(.NUM_SLV(4), .TIMEOUT_CYC(255)) dut (
    .pll_core_cpuclk(clk),
    .pad_cpu_rst_b  (rst_n),
    .hsel           (hsel),
    .haddr          (haddr),
    .htrans         (htrans),
    .hwrite         (hwrite),
    .hsize          (hsize),
    .hwdata         (hwdata),
    .hrdata         (hrdata),
    .hready         (hready),
    .hresp          (hresp),
    .paddr          (paddr),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr)
  );

  always #5 clk = ~clk;

`ifdef APB_XFER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int unsigned TO_CYC = 255;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int unsigned waits;
    logic        slverr;
    logic [31:0] rdata;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  bit resp_en = 1'b0;

  plan_t       cur;
  bit          have_cur = 1'b0;
  int unsigned k = 0;
  bit          prev_pen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: this computes the expected outcome from the transfer rules alone.
  task automatic issue(input logic [39:0] a, input logic wr, input logic [2:0] sz,
                       input logic [31:0] wd, input int unsigned waits,
                       input logic se, input logic [31:0] rd);
    exp_t        e;
    plan_t       p;
    logic        aerr;
    int unsigned n;
    aerr = (a[39:16] != 24'h0) || (sz > 3'd2);
    if (aerr)                         e = '{err: 1'b1, rdata: 32'h0, cyc: 2};
    else if (TO_EN && waits >= TO_CYC) e = '{err: 1'b1, rdata: 32'h0, cyc: TO_CYC + 3};
    else if (se)                      e = '{err: 1'b1, rdata: 32'h0, cyc: waits + 4};
    else                              e = '{err: 1'b0, rdata: (wr ? 32'h0 : rd), cyc: waits + 2};
    exp_q.push_back(e);
    if (!aerr) begin
      p.idx = a[13:12]; p.addr = a[31:0]; p.wr = wr; p.wdata = wd;
      p.waits = waits; p.slverr = se; p.rdata = rd;
      plan_q.push_back(p);
    end
    hsel = 1'b1; htrans = {1'b1, 1'($urandom)}; haddr = a; hwrite = wr; hsize = sz;
    n = 0;
    @(negedge clk);
    while (!hready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!hready) begin
      checks++; failures++;
      $display("FAIL accept_wait actual=hready_low required=hready_high at %0t", $time);
    end
    @(posedge clk); #1;
    hwdata = wd;
    hsel   = 1'($urandom);
    htrans = {1'b0, 1'($urandom)};
    haddr  = 40'({$urandom, $urandom});
    hwrite = 1'($urandom);
    hsize  = 3'($urandom);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      hsel = 1'($urandom); htrans = {1'b0, 1'($urandom)};
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    idle(2);
    chk("sb_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("sb_plan_empty", 64'(plan_q.size()), 64'd0);
  endtask

  task automatic rand_xfers(input int unsigned cnt);
    logic [39:0] a;
    logic [2:0]  sz;
    int unsigned r, w;
    for (int unsigned i = 0; i < cnt; i++) begin
      a = {24'h0, 16'($urandom)};
      r = $urandom_range(0, 9);
      if (r == 0) a[39:16] = 24'($urandom_range(1, 24'hFFFFFF));
      sz = 3'($urandom_range(0, 2));
      if (r == 1) sz = 3'($urandom_range(3, 7));
      w = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 4);
      issue(a, 1'($urandom), sz, $urandom, w, ($urandom_range(0, 5) == 0), $urandom);
      idle(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 2));
    end
  endtask

  // APB peripheral responder. It releases pready after the planned number of wait cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!penable) have_cur = 1'b0;
      if (resp_en) begin
        pready  = 4'($urandom);
        pslverr = 4'($urandom);
        prdata  = {$urandom, $urandom, $urandom, $urandom};
        if (penable && psel != 4'b0 && !prev_pen) begin
          if (plan_q.size() != 0) begin
            cur = plan_q.pop_front();
            have_cur = 1'b1;
            k = 0;
          end else begin
            checks++; failures++;
            $display("FAIL plan_underflow actual=access required=no_access at %0t", $time);
          end
        end
        if (have_cur) begin
          pready[cur.idx]  = (k == cur.waits);
          pslverr[cur.idx] = cur.slverr && (k == cur.waits);
          prdata[int'(cur.idx)*32 +: 32] = cur.rdata;
          k++;
        end
      end else begin
        pready = '0; pslverr = '0; prdata = '0;
      end
      prev_pen = penable;
    end
  end

  // AHB response monitor.
  initial begin
    bit          dp = 1'b0;
    bit          prev_err1 = 1'b0;
    int unsigned cyc = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        dp = 1'b0; prev_err1 = 1'b0;
      end else begin
        if (dp) begin
          cyc++;
          if (hready) begin
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL sb_underflow actual=completion required=none at %0t", $time);
            end else begin
              e = exp_q.pop_front();
              chk("hresp", 64'(hresp), e.err ? 64'd1 : 64'd0);
              chk("hrdata", 64'(hrdata), 64'(e.rdata));
              chk("latency", 64'(cyc), 64'(e.cyc));
              if (e.err) chk("err_first_cycle", 64'(prev_err1), 64'd1);
            end
            dp = 1'b0;
          end
        end else begin
          chk("idle_hready", 64'(hready), 64'd1);
          chk("idle_hresp", 64'(hresp), 64'd0);
        end
        prev_err1 = !hready && (hresp == 2'b01);
        if (hsel && htrans[1] && hready) begin
          dp = 1'b1; cyc = 0;
        end
      end
    end
  end

  // APB bus monitor.
  initial begin
    plan_t p;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (psel != 4'b0) begin
          chk("psel_onehot", 64'($onehot(psel)), 64'd1);
          if (!penable) begin
            if (plan_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_setup actual=psel_%0h required=none at %0t", psel, $time);
            end else begin
              p = plan_q[0];
              chk("setup_psel", 64'(psel), 64'(4'b0001 << p.idx));
              chk("setup_paddr", 64'(paddr), 64'(p.addr));
              chk("setup_pwrite", 64'(pwrite), 64'(p.wr));
              if (p.wr) chk("setup_pwdata", 64'(pwdata), 64'(p.wdata));
            end
          end else if (have_cur) begin
            chk("access_psel", 64'(psel), 64'(4'b0001 << cur.idx));
            chk("access_paddr", 64'(paddr), 64'(cur.addr));
            chk("access_pwrite", 64'(pwrite), 64'(cur.wr));
            if (cur.wr) chk("access_pwdata", 64'(pwdata), 64'(cur.wdata));
          end
        end else begin
          chk("penable_without_psel", 64'(penable), 64'd0);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Main stimulus sequence.
  initial begin
    int unsigned n;
    #12;
    chk("rst_hready", 64'(hready), 64'd1);
    chk("rst_hresp", 64'(hresp), 64'd0);
    chk("rst_hrdata", 64'(hrdata), 64'd0);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1; resp_en = 1'b1;
    idle(1);

    issue(40'h00_0000_2008, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    idle(2);
    issue(40'h00_0000_1000, 1'b0, 3'd2, 32'h0, 3, 1'b0, 32'h1234_5678);
    idle(1);
    issue(40'h00_0000_3010, 1'b1, 3'd2, 32'hA5A5_0001, 0, 1'b0, 32'h0);
    issue(40'h00_0000_0020, 1'b0, 3'd1, 32'h0, 1, 1'b0, 32'h0BAD_F00D);
    idle(1);
    issue(40'h00_0001_0000, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0);
    issue(40'h00_0000_1004, 1'b1, 3'd3, 32'h1111_2222, 0, 1'b0, 32'h0);
    issue(40'h00_0000_2004, 1'b0, 3'd0, 32'h0, 0, 1'b0, 32'hCAFE_0002);
    idle(1);
    issue(40'h00_0000_2100, 1'b0, 3'd2, 32'h0, 2, 1'b1, 32'h7777_8888);
    issue(40'h00_0000_0100, 1'b1, 3'd2, 32'h3333_4444, 0, 1'b1, 32'h0);
    idle(1);
    issue(40'h00_0000_3000, 1'b0, 3'd2, 32'h0, 300, 1'b0, 32'h5555_AAAA);
    idle(1);
    rand_xfers(80);
    drain();

    // Reset asserted in the middle of an ACCESS phase.
    mon_en = 1'b0; resp_en = 1'b0;
    idle(1);
    hsel = 1'b1; htrans = 2'b10; haddr = 40'h00_0000_3004; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFE_F00D;
    n = 0;
    while (!penable && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre_reset_access", 64'(penable), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", 64'(psel), 64'd0);
    chk("mid_rst_penable", 64'(penable), 64'd0);
    chk("mid_rst_hready", 64'(hready), 64'd1);
    chk("mid_rst_hresp", 64'(hresp), 64'd0);
    chk("mid_rst_paddr", 64'(paddr), 64'd0);
    chk("mid_rst_pwdata", 64'(pwdata), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1; resp_en = 1'b1;
    idle(1);
    issue(40'h00_0000_2008, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    issue(40'h00_0000_1000, 1'b0, 3'd2, 32'h0, 2, 1'b0, 32'h1234_5678);
    rand_xfers(15);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
